// File: rtl/lab3_qs_mem_scrubber_if.sv
`default_nettype none
// ============================================================================
// Module   : lab3_qs_mem_scrubber_if
// Purpose  : Word-wide on-chip RAM bus between the scrubber (master) and the
//            RAM (slave). Read data returns one cycle after the address.
// Revision : 1.0 - initial release
// ============================================================================
interface lab3_qs_mem_scrubber_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              mem_clken;
   logic [31:0]       mem_readdata;

   modport master (
      output mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport slave (
      input  mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface
`default_nettype wire

// File: rtl/lab3_qs_mem_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : lab3_qs_mem_scrubber
// Purpose  : Fills a RAM window with the pattern seed+address and/or reads it
//            back, counting mismatches and recording the first bad address.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_qs_mem_scrubber #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 10000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] count,
   input  logic [31:0]       seed,
   output logic              busy,
   output logic              done,
   output logic              range_err,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   lab3_qs_mem_scrubber_if.master bus
);

   localparam logic [ADDR_W:0] c_depth   = (ADDR_W+1)'(DEPTH);
   localparam logic [15:0]     c_err_max = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_VERIFY = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_count;
   logic [31:0]       r_seed;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_left;
   logic              r_cmp_valid;
   logic [ADDR_W-1:0] r_cmp_addr;
   logic              r_range_err;
   logic [15:0]       r_err_count;
   logic [ADDR_W-1:0] r_first_err_addr;

   logic              w_accept;
   logic [ADDR_W:0]   w_end;
   logic              w_range_bad;
   logic              w_last;
   logic              w_active;
   logic [31:0]       w_pattern_cmp;
   logic              w_mismatch;

   // start is only honoured from IDLE, and a coincident abort suppresses it
   assign w_accept      = (r_state == S_IDLE) && start && !abort;
   // one extra bit so base+count cannot wrap before the depth check
   assign w_end         = {1'b0, base} + {1'b0, count};
   assign w_range_bad   = w_end > c_depth;
   assign w_last        = (r_left == ADDR_W'(1));
   assign w_active      = (r_state == S_FILL) || (r_state == S_VERIFY);
   assign w_pattern_cmp = r_seed + 32'(r_cmp_addr);
   // an abort discards whatever compare is in flight
   assign w_mismatch    = r_cmp_valid && !abort && (bus.mem_readdata != w_pattern_cmp);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; abort overrides everything outside IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_range_bad || (count == '0)) w_next = S_DONE;
               else if (mode == 2'd2)            w_next = S_VERIFY;
               else                              w_next = S_FILL;
            end
         end
         S_FILL:   if (w_last) w_next = (r_mode == 2'd1) ? S_VERIFY : S_DONE;
         S_VERIFY: if (w_last) w_next = S_DRAIN;
         S_DRAIN:  w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
   end

   // Operand latch, address walk, read-compare pipeline and error tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode           <= '0;
         r_base           <= '0;
         r_count          <= '0;
         r_seed           <= '0;
         r_addr           <= '0;
         r_left           <= '0;
         r_cmp_valid      <= 1'b0;
         r_cmp_addr       <= '0;
         r_range_err      <= 1'b0;
         r_err_count      <= '0;
         r_first_err_addr <= '0;
      end else begin
         r_cmp_valid <= (r_state == S_VERIFY) && !abort;
         r_cmp_addr  <= r_addr;

         if (w_mismatch) begin
            if (r_err_count == '0)       r_first_err_addr <= r_cmp_addr;
            if (r_err_count != c_err_max) r_err_count     <= r_err_count + 16'd1;
         end

         if (w_accept) begin
            r_mode           <= mode;
            r_base           <= base;
            r_count          <= count;
            r_seed           <= seed;
            r_addr           <= base;
            r_left           <= count;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_range_err      <= w_range_bad;
         end else if ((r_state == S_FILL) && w_last) begin
            // rewind for a possible verify pass over the same window
            r_addr <= r_base;
            r_left <= r_count;
         end else if (w_active) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_left <= r_left - ADDR_W'(1);
         end
      end
   end

   assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done           = (r_state == S_DONE);
   assign range_err      = r_range_err;
   assign err_count      = r_err_count;
   assign first_err_addr = r_first_err_addr;

   // Bus is driven purely from state, so reset silences it immediately
   assign bus.mem_chipselect = w_active;
   assign bus.mem_write      = (r_state == S_FILL);
   assign bus.mem_address    = w_active ? r_addr : '0;
   assign bus.mem_writedata  = (r_state == S_FILL) ? (r_seed + 32'(r_addr)) : 32'd0;
   assign bus.mem_byteenable = 4'hF;
   assign bus.mem_clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lab3_qs_mem_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab3_qs_mem_scrubber
// Purpose  : Self-checking bench for lab3_qs_mem_scrubber with a RAM model
//            and a window-level reference model of fill/verify results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab3_qs_mem_scrubber;

   localparam int          ADDR_W   = 14;
   localparam int          DEPTH    = 10000;
   localparam logic [31:0] COR_MASK = 32'h0000_0100;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] count;
   logic [31:0]       seed;
   logic              busy;
   logic              done;
   logic              range_err;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;

   lab3_qs_mem_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

   lab3_qs_mem_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .mode           (mode),
      .base           (base),
      .count          (count),
      .seed           (seed),
      .busy           (busy),
      .done           (done),
      .range_err      (range_err),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   bit [31:0] ram     [DEPTH];
   bit [31:0] ref_mem [DEPTH];
   bit        cor_en;
   int        cor_a;
   int        wq_a [$];
   logic [31:0] wq_d [$];
   int        rq_a [$];
   int        done_cnt = 0;
   int        n_cmp = 0;
   int        n_fail = 0;

   // RAM model: synchronous write, one-cycle read latency, optional corruption
   always @(posedge clk) begin
      if (bus.mem_chipselect && (int'(bus.mem_address) < DEPTH)) begin
         if (bus.mem_write)
            ram[bus.mem_address] <= bus.mem_writedata;
         else
            bus.mem_readdata <= ram[bus.mem_address] ^
               ((cor_en && (int'(bus.mem_address) == cor_a)) ? COR_MASK : 32'h0);
      end
   end

   // Access and done-pulse monitor
   always @(negedge clk) begin
      if (bus.mem_chipselect) begin
         if (bus.mem_write) begin
            wq_a.push_back(int'(bus.mem_address));
            wq_d.push_back(bus.mem_writedata);
         end else begin
            rq_a.push_back(int'(bus.mem_address));
         end
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wq_a.delete();
      wq_d.delete();
      rq_a.delete();
   endtask

   // One operation against the reference model; restart_at drives a second
   // start (with different operands) at that cycle, which must be ignored.
   task automatic run_op(input logic [1:0] md, input int b, input int c,
                         input logic [31:0] sd, input bit ce, input int ca,
                         input int restart_at, input string tag);
      int eff, exp_lat, exp_w, exp_r, exp_err, exp_first;
      int lat, busy_cyc, d0, wbad, rbad;
      bit bad, do_fill, do_ver;
      logic [31:0] v;

      eff     = (md == 2'd3) ? 0 : int'(md);
      bad     = (b + c) > DEPTH;
      do_fill = !bad && (c > 0) && (eff != 2);
      do_ver  = !bad && (c > 0) && (eff != 0);
      exp_lat = (bad || c == 0) ? 1 : (eff == 0) ? c + 1 : (eff == 1) ? 2*c + 2 : c + 2;
      exp_w   = do_fill ? c : 0;
      exp_r   = do_ver  ? c : 0;
      if (do_fill)
         for (int i = 0; i < c; i++) ref_mem[b+i] = sd + 32'(b + i);
      exp_err   = 0;
      exp_first = 0;
      if (do_ver)
         for (int i = 0; i < c; i++) begin
            v = ref_mem[b+i] ^ ((ce && (b + i) == ca) ? COR_MASK : 32'h0);
            if (v != sd + 32'(b + i)) begin
               if (exp_err == 0) exp_first = b + i;
               exp_err++;
            end
         end

      @(negedge clk);
      cor_en = ce;
      cor_a  = ca;
      clear_log();
      d0    = done_cnt;
      mode  = md;
      base  = ADDR_W'(b);
      count = ADDR_W'(c);
      seed  = sd;
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cyc = 0;
      while (!done && lat < 2*c + 20) begin
         if (busy) busy_cyc++;
         if (lat == restart_at) begin
            start = 1'b1;
            seed  = ~sd;
            mode  = 2'd0;
         end else begin
            start = 1'b0;
            seed  = sd;
            mode  = md;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      seed  = sd;
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat - 1));
      @(negedge clk);
      #1;
      chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
      chk({tag, "_range_err"}, 64'(range_err), 64'(bad));
      chk({tag, "_writes"}, 64'(wq_a.size()), 64'(exp_w));
      wbad = 0;
      for (int i = 0; i < wq_a.size() && i < exp_w; i++)
         if (wq_a[i] != b + i || wq_d[i] !== sd + 32'(b + i)) wbad++;
      chk({tag, "_write_content"}, 64'(wbad), 64'd0);
      chk({tag, "_reads"}, 64'(rq_a.size()), 64'(exp_r));
      rbad = 0;
      for (int i = 0; i < rq_a.size() && i < exp_r; i++)
         if (rq_a[i] != b + i) rbad++;
      chk({tag, "_read_addr"}, 64'(rbad), 64'd0);
      chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
      chk({tag, "_first_err"}, 64'(first_err_addr), 64'(exp_first));
      cor_en = 1'b0;
   endtask

   initial begin
      int d0, cyc, md, c, b, ca, rs;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = '0;
      base  = '0;
      count = '0;
      seed  = '0;
      cor_en = 1'b0;
      cor_a  = 0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_range_err", 64'(range_err), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_first_err", 64'(first_err_addr), 64'd0);
      chk("rst_bus", {bus.mem_address, bus.mem_chipselect, bus.mem_write, bus.mem_writedata}, 64'd0);
      chk("rst_be_clken", {bus.mem_byteenable, bus.mem_clken}, 64'h1F);
      reset = 1'b0;

      // directed operations
      run_op(2'd1, 'h100, 16, 32'hA5A5_0000, 1'b0, 0,     -1, "fillver");
      run_op(2'd1, 'h100, 16, 32'hA5A5_0000, 1'b1, 'h105, -1, "fault");
      run_op(2'd1, 9990,  20, 32'h1234_5678, 1'b0, 0,     -1, "range");
      run_op(2'd0, 'h40,   0, 32'h0000_0001, 1'b0, 0,     -1, "zero");
      run_op(2'd0, 'h200, 10, 32'hDEAD_BEEF, 1'b0, 0,      3, "restart");
      run_op(2'd3, 'h300,  5, 32'hFFFF_FFFE, 1'b0, 0,     -1, "mode3");
      run_op(2'd2, 'h200, 10, 32'hDEAD_BEEF, 1'b0, 0,     -1, "verify_only");

      // randomized operations
      for (int k = 0; k < 10; k++) begin
         md = int'($urandom_range(3));
         c  = int'($urandom_range(40, 1));
         if ($urandom_range(4) == 0) b = int'($urandom_range(DEPTH - 1, DEPTH - c + 1));
         else                        b = int'($urandom_range(DEPTH - c, 0));
         ca = b + int'($urandom_range(c - 1));
         rs = ($urandom_range(1) == 1) ? int'($urandom_range(4, 1)) : -1;
         run_op(2'(md), b, c, $urandom, 1'($urandom_range(1)), ca, rs, "rand");
      end

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      d0    = done_cnt;
      count = ADDR_W'(4);
      base  = ADDR_W'(0);
      mode  = 2'd0;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("idle_abort_busy", {63'd0, busy}, 64'd0);
      chk("idle_abort_cs", {63'd0, bus.mem_chipselect}, 64'd0);
      @(negedge clk);
      #1;
      chk("idle_abort_done", 64'(done_cnt - d0), 64'd0);

      // abort on the 50th write of a 100-word fill+verify
      @(negedge clk);
      clear_log();
      d0    = done_cnt;
      mode  = 2'd1;
      base  = ADDR_W'(500);
      count = ADDR_W'(100);
      seed  = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_write_active", {62'd0, bus.mem_chipselect, bus.mem_write}, 64'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_cs", {63'd0, bus.mem_chipselect}, 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      repeat (120) @(negedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      chk("abort_writes", 64'(wq_a.size()), 64'd50);
      chk("abort_reads", 64'(rq_a.size()), 64'd0);
      for (int i = 0; i < 50; i++) ref_mem[500+i] = seed + 32'(500 + i);

      // asynchronous reset in the middle of a verify pass
      @(negedge clk);
      mode  = 2'd2;
      base  = ADDR_W'(1000);
      count = ADDR_W'(20);
      seed  = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("arst_in_verify", {61'd0, busy, bus.mem_chipselect, bus.mem_write}, 64'd6);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_bus", {bus.mem_address, bus.mem_chipselect, bus.mem_write, bus.mem_writedata}, 64'd0);
      chk("arst_status", {busy, done, range_err, err_count, first_err_addr}, 64'd0);
      chk("arst_be_clken", {bus.mem_byteenable, bus.mem_clken}, 64'h1F);
      @(negedge clk);
      reset = 1'b0;
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      #1;
      chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
      chk("arst_idle", {62'd0, busy, bus.mem_chipselect}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lab3_qs_mem_scrubber.md
LAB3_QS_MEM_SCRUBBER -- requirements
Module: lab3_qs_mem_scrubber

Interface
REQ-001 SHALL have parameters: ADDR_W, default 14, memory word-address width; DEPTH, default 10000, memory size in 32-bit words.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that launches an operation from IDLE.
REQ-005 abort  input  1  level; terminates any running operation.
REQ-006 mode  input  2  0 = fill only, 1 = fill then verify, 2 = verify only, 3 = reserved (treated as 0).
REQ-007 base  input  ADDR_W  first word address; sampled on start.
REQ-008 count  input  ADDR_W  number of words; sampled on start.
REQ-009 seed  input  32  pattern seed; sampled on start.
REQ-010 busy  output  1  high while not in IDLE/DONE.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 range_err  output  1  sticky until next start; set when base+count > DEPTH.
REQ-013 err_count  output  16  verify mismatches, saturating at 0xFFFF.
REQ-014 first_err_addr  output  ADDR_W  address of the first mismatch.
REQ-015 mem_address  output  ADDR_W  word address to the on-chip RAM.
REQ-016 mem_byteenable  output  4  always 4'hF.
REQ-017 mem_chipselect  output  1  RAM select.
REQ-018 mem_write  output  1  RAM write strobe.
REQ-019 mem_writedata  output  32  RAM write data.
REQ-020 mem_clken  output  1  RAM clock enable; held at 1.
REQ-021 mem_readdata  input  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-022 The pattern for word address a SHALL be P(a) = seed + zero-extended a, computed modulo 2^32.
REQ-023 The FSM SHALL have states IDLE, FILL, VERIFY, DRAIN and DONE; start SHALL be ignored outside IDLE.
REQ-024 On start, base/count/seed/mode SHALL be latched, and err_count, first_err_addr and range_err SHALL be cleared.
REQ-025 On start with base+count > DEPTH (computed at ADDR_W+1 bits), range_err SHALL be set and the FSM SHALL go to DONE without issuing any RAM access.
REQ-026 On start with count = 0, the FSM SHALL go to DONE without issuing any RAM access.
REQ-027 In FILL, one write SHALL be issued per cycle: chipselect=1, write=1, address = base+i, writedata = P(base+i), for i = 0..count-1.
REQ-028 After the last write, FILL SHALL go to VERIFY if mode=1, otherwise to DONE.
REQ-029 Mode 2 SHALL enter VERIFY directly from IDLE.
REQ-030 In VERIFY, one read SHALL be issued per cycle: chipselect=1, write=0, address = base+i.
REQ-031 The returned data SHALL be compared one cycle later against P of the registered address.
REQ-032 After the last read issue, VERIFY SHALL go to DRAIN for exactly one cycle to perform the final compare, then go to DONE.
REQ-033 On each mismatch, err_count SHALL increment (saturating), and first_err_addr SHALL load only when err_count was 0.
REQ-034 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-035 abort SHALL override all other conditions in any non-IDLE state: next state is IDLE, no done pulse, and any compare pending in DRAIN is discarded.
REQ-036 When start and abort coincide in IDLE, abort SHALL win.
REQ-037 mem_chipselect SHALL be 0 in IDLE, DRAIN and DONE.
REQ-038 Total latency from start to done SHALL be count+1 cycles for mode 0, 2*count+2 for mode 1, and count+2 for mode 2; count=0 or a range error SHALL give done one cycle after start.

Reset
REQ-039 While reset is asserted: state=IDLE; busy, done, range_err, err_count, first_err_addr, mem_address, mem_chipselect, mem_write and mem_writedata all 0; mem_byteenable=4'hF; mem_clken=1.
REQ-040 Reset asserted mid-operation SHALL stop RAM accesses immediately (asynchronously), and no done pulse SHALL follow.

Verification
REQ-041 Fill+verify: mode=1, base=0x100, count=16, seed=0xA5A50000 -> 16 writes with data 0xA5A50100..0xA5A5010F, then 16 reads; done at cycle 34; err_count=0.
REQ-042 Injected fault: the bench model corrupts the word at 0x105 on read -> err_count=1, first_err_addr=0x105.
REQ-043 Range: base=9990, count=20 -> range_err=1, done one cycle after start, zero RAM accesses.
REQ-044 Abort: mode=1, count=100, abort asserted on the 50th write -> chipselect=0 next cycle, busy=0, no done pulse.
REQ-045 Edge cases: count=0 -> done after one cycle with no accesses; a start while busy is ignored.
REQ-046 Async reset asserted mid-VERIFY between clock edges -> all outputs at reset values before the next clock edge.
